// File: rtl/pe_window_sched.sv
// pe_window_sched: issues one input-map and one weight read per cycle for a KxK, ICH-channel
// valid convolution, delays the PE valid to match buffer latency, and stores each PE result.
module pe_window_sched #(
    parameter int K       = 5,
    parameter int ICH     = 1,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 28,
    parameter int IMAP_AW = 10,
    parameter int W_AW    = 5,
    parameter int OMAP_AW = 10
) (
    input  logic               clk_cal,
    input  logic               rst_cal,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [IMAP_AW-1:0] imap_addr,
    output logic [W_AW-1:0]    w_addr,
    output logic               pe_imap_vld,
    output logic               pe_weight_vld,
    input  logic [7:0]         pe_omap,
    input  logic               pe_omap_vld,
    output logic               obuf_we,
    output logic [OMAP_AW-1:0] obuf_addr,
    output logic [7:0]         obuf_data
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one read issued per cycle unless hold
    // DRAIN | last read's data reaches the PE
    // DONE  | done pulse, back to IDLE next cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int CW = 16;
    localparam logic [CW-1:0]      K_LAST   = CW'(K - 1);
    localparam logic [CW-1:0]      CH_LAST  = CW'(ICH - 1);
    localparam logic [CW-1:0]      O_LAST   = CW'(OUT_W - 1);
    localparam logic [IMAP_AW-1:0] ROW_STEP = IMAP_AW'(IN_W);
    localparam logic [IMAP_AW-1:0] CH_STEP  = IMAP_AW'(IN_W * IN_W);

    state_e state_q, state_d;

    logic [CW-1:0]      kx_q, kx_d;
    logic [CW-1:0]      ky_q, ky_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [CW-1:0]      ox_q, ox_d;
    logic [CW-1:0]      oy_q, oy_d;
    logic [IMAP_AW-1:0] rowoff_q, rowoff_d;
    logic [IMAP_AW-1:0] chbase_q, chbase_d;
    logic [IMAP_AW-1:0] oybase_q, oybase_d;
    logic [W_AW-1:0]    w_addr_q, w_addr_d;

    logic               pe_vld_q;
    logic               obuf_we_q;
    logic [OMAP_AW-1:0] obuf_addr_q;
    logic [OMAP_AW-1:0] wcnt_q;
    logic [7:0]         obuf_data_q;

    logic start_acc;
    logic issue;
    logic kx_wrap, ky_wrap, pix_wrap, row_wrap, map_wrap;
    logic capture;

    assign start_acc = (state_q == S_IDLE) && start;
    assign issue     = (state_q == S_RUN) && !hold;

    // Wrap chain: each level only rolls over when every inner level rolls over too.
    assign kx_wrap  = (kx_q == K_LAST);
    assign ky_wrap  = kx_wrap && (ky_q == K_LAST);
    assign pix_wrap = ky_wrap && (ch_q == CH_LAST);
    assign row_wrap = pix_wrap && (ox_q == O_LAST);
    assign map_wrap = row_wrap && (oy_q == O_LAST);

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rd_en = !hold;
                if (issue && map_wrap) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        kx_d     = kx_q;
        ky_d     = ky_q;
        ch_d     = ch_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        rowoff_d = rowoff_q;
        chbase_d = chbase_q;
        oybase_d = oybase_q;
        w_addr_d = w_addr_q;
        if (start_acc) begin
            kx_d     = '0;
            ky_d     = '0;
            ch_d     = '0;
            ox_d     = '0;
            oy_d     = '0;
            rowoff_d = '0;
            chbase_d = '0;
            oybase_d = '0;
            w_addr_d = '0;
        end else if (issue) begin
            kx_d     = kx_wrap ? '0 : kx_q + 1'b1;
            w_addr_d = pix_wrap ? '0 : w_addr_q + 1'b1;
            if (kx_wrap) begin
                ky_d     = ky_wrap ? '0 : ky_q + 1'b1;
                rowoff_d = ky_wrap ? '0 : rowoff_q + ROW_STEP;
            end
            if (ky_wrap) begin
                ch_d     = pix_wrap ? '0 : ch_q + 1'b1;
                chbase_d = pix_wrap ? '0 : chbase_q + CH_STEP;
            end
            if (pix_wrap) begin
                ox_d = row_wrap ? '0 : ox_q + 1'b1;
            end
            if (row_wrap) begin
                oy_d     = map_wrap ? '0 : oy_q + 1'b1;
                oybase_d = map_wrap ? '0 : oybase_q + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            state_q  <= S_IDLE;
            kx_q     <= '0;
            ky_q     <= '0;
            ch_q     <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            rowoff_q <= '0;
            chbase_q <= '0;
            oybase_q <= '0;
            w_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            kx_q     <= kx_d;
            ky_q     <= ky_d;
            ch_q     <= ch_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            rowoff_q <= rowoff_d;
            chbase_q <= chbase_d;
            oybase_q <= oybase_d;
            w_addr_q <= w_addr_d;
        end
    end

    // A PE result is only trusted while our own valid is presented; the final write of a
    // map therefore lands in the cycle that carries the done pulse.
    assign capture = pe_vld_q && pe_omap_vld;

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            pe_vld_q    <= 1'b0;
            obuf_we_q   <= 1'b0;
            obuf_addr_q <= '0;
            obuf_data_q <= '0;
            wcnt_q      <= '0;
        end else begin
            pe_vld_q  <= rd_en;
            obuf_we_q <= capture;
            if (capture) begin
                obuf_data_q <= pe_omap;
                obuf_addr_q <= wcnt_q;
                wcnt_q      <= wcnt_q + 1'b1;
            end else if (start_acc) begin
                obuf_addr_q <= '0;
                wcnt_q      <= '0;
            end
        end
    end

    assign imap_addr     = chbase_q + oybase_q + rowoff_q + IMAP_AW'(ox_q) + IMAP_AW'(kx_q);
    assign w_addr        = w_addr_q;
    assign pe_imap_vld   = pe_vld_q;
    assign pe_weight_vld = pe_vld_q;
    assign obuf_we       = obuf_we_q;
    assign obuf_addr     = obuf_addr_q;
    assign obuf_data     = obuf_data_q;

endmodule

// File: tb/tb_pe_window_sched.sv
// Directed bench for pe_window_sched: small K=2 map with a behavioural PE, plus one
// full default-parameter map checked for issue/write totals and final addresses.
module tb_pe_window_sched;

    logic clk;
    logic rst, start, hold;
    logic busy, done, rd_en;
    logic [3:0] imap_addr;
    logic [1:0] w_addr;
    logic pe_imap_vld, pe_weight_vld;
    logic [7:0] pe_omap;
    logic pe_omap_vld;
    logic obuf_we;
    logic [1:0] obuf_addr;
    logic [7:0] obuf_data;

    logic d_start, d_hold;
    logic d_busy, d_done, d_rd_en;
    logic [9:0] d_imap_addr;
    logic [4:0] d_w_addr;
    logic d_pe_vld, d_pe_wvld;
    logic [7:0] d_omap;
    logic d_omap_vld;
    logic d_obuf_we;
    logic [9:0] d_obuf_addr;
    logic [7:0] d_obuf_data;

    int n_vec, n_bad;
    int exp_ia [16] = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pe_window_sched #(.K(2), .ICH(1), .IN_W(3), .OUT_W(2), .IMAP_AW(4), .W_AW(2), .OMAP_AW(2)) u_dut (
        .clk_cal(clk), .rst_cal(rst), .start(start), .hold(hold),
        .busy(busy), .done(done), .rd_en(rd_en),
        .imap_addr(imap_addr), .w_addr(w_addr),
        .pe_imap_vld(pe_imap_vld), .pe_weight_vld(pe_weight_vld),
        .pe_omap(pe_omap), .pe_omap_vld(pe_omap_vld),
        .obuf_we(obuf_we), .obuf_addr(obuf_addr), .obuf_data(obuf_data)
    );

    pe_window_sched u_dflt (
        .clk_cal(clk), .rst_cal(rst), .start(d_start), .hold(d_hold),
        .busy(d_busy), .done(d_done), .rd_en(d_rd_en),
        .imap_addr(d_imap_addr), .w_addr(d_w_addr),
        .pe_imap_vld(d_pe_vld), .pe_weight_vld(d_pe_wvld),
        .pe_omap(d_omap), .pe_omap_vld(d_omap_vld),
        .obuf_we(d_obuf_we), .obuf_addr(d_obuf_addr), .obuf_data(d_obuf_data)
    );

    // Buffers with one-cycle read latency and a PE that sums (imap*w)>>3 over 4 products.
    logic [7:0] imem [16];
    logic [7:0] wmem [4];
    logic [7:0] ibuf_q, wbuf_q;
    logic [15:0] acc_q, prod;
    int pe_cnt;

    assign prod        = (16'(ibuf_q) * 16'(wbuf_q)) >> 3;
    assign pe_omap_vld = pe_imap_vld && (pe_cnt == 3);
    assign pe_omap     = 8'(acc_q + prod);

    always @(posedge clk) begin
        if (rd_en) begin
            ibuf_q <= imem[imap_addr];
            wbuf_q <= wmem[w_addr];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= 16'd0;
            pe_cnt <= 0;
        end else if (pe_imap_vld) begin
            if (pe_cnt == 3) begin
                acc_q  <= 16'd0;
                pe_cnt <= 0;
            end else begin
                acc_q  <= acc_q + prod;
                pe_cnt <= pe_cnt + 1;
            end
        end
    end

    int d_cnt;
    assign d_omap     = 8'h5A;
    assign d_omap_vld = d_pe_vld && (d_cnt == 24);
    always @(posedge clk or posedge rst) begin
        if (rst) d_cnt <= 0;
        else if (d_pe_vld) d_cnt <= (d_cnt == 24) ? 0 : d_cnt + 1;
    end

    // Cumulative monitors sampled on the falling edge; tests use before/after snapshots.
    int ia_q[$], wa_q[$], oa_q[$], od_q[$];
    int vld_cnt, vld_neq;
    int d_issues, d_writes, d_last_ia, d_last_wa, d_last_oa, d_last_od, d_neq;
    initial begin
        vld_cnt = 0; vld_neq = 0;
        d_issues = 0; d_writes = 0; d_last_ia = -1; d_last_wa = -1;
        d_last_oa = -1; d_last_od = -1; d_neq = 0;
    end
    always @(negedge clk) begin
        if (rd_en) begin
            ia_q.push_back(int'(imap_addr));
            wa_q.push_back(int'(w_addr));
        end
        if (obuf_we) begin
            oa_q.push_back(int'(obuf_addr));
            od_q.push_back(int'(obuf_data));
        end
        if (pe_imap_vld) vld_cnt++;
        if (pe_imap_vld !== pe_weight_vld) vld_neq++;
        if (d_rd_en) begin
            d_issues++;
            d_last_ia = int'(d_imap_addr);
            d_last_wa = int'(d_w_addr);
        end
        if (d_obuf_we) begin
            d_writes++;
            d_last_oa = int'(d_obuf_addr);
            d_last_od = int'(d_obuf_data);
        end
        if (d_pe_vld !== d_pe_wvld) d_neq++;
    end

    // Drives one map; cycle 1 is the first cycle after the edge that samples start.
    task automatic run_map(input int hold_after, input int hold_len, input int restart_cyc,
                           output int done_cyc, output int gap_bad);
        int cyc, gap, ib0;
        logic hold_prev;
        ib0 = ia_q.size();
        done_cyc = -1; gap_bad = 0; gap = 0; hold_prev = 1'b0; cyc = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cyc = 1;
        while (done_cyc < 0 && cyc < 300) begin
            if (hold_prev && pe_imap_vld) gap_bad++;
            start = (cyc == restart_cyc);
            if (hold_after > 0 && (ia_q.size() - ib0) == hold_after && gap < hold_len) begin
                hold = 1'b1;
                gap++;
            end else begin
                hold = 1'b0;
            end
            #1;
            if (hold && rd_en) gap_bad++;
            hold_prev = hold;
            if (done) done_cyc = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        hold = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({busy, done, rd_en, pe_imap_vld, pe_weight_vld, obuf_we} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {busy, done, rd_en, pe_imap_vld, pe_weight_vld, obuf_we});
        end
        n_vec++;
        if (imap_addr !== 4'd0 || w_addr !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_addr: got imap %0d w %0d expected 0 0", imap_addr, w_addr);
        end
        n_vec++;
        if (obuf_addr !== 2'd0 || obuf_data !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_obuf: got addr %0d data %0h expected 0 0", obuf_addr, obuf_data);
        end
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy %b rd_en %b expected 0 0", busy, rd_en);
        end
    endtask

    task automatic test_base_map();
        int ib, ob, dc, gb, vb, got;
        ib = ia_q.size(); ob = oa_q.size(); vb = vld_cnt;
        run_map(0, 0, 0, dc, gb);
        n_vec++;
        if (dc !== 18) begin n_bad++; $display("FAIL base_done_cycle: got %0d expected 18", dc); end
        n_vec++;
        if (ia_q.size() - ib !== 16) begin
            n_bad++; $display("FAIL base_issue_count: got %0d expected 16", ia_q.size() - ib);
        end
        n_vec++;
        if (vld_cnt - vb !== 16 || vld_neq !== 0) begin
            n_bad++; $display("FAIL base_pe_vld: got %0d cycles, %0d unequal expected 16, 0", vld_cnt - vb, vld_neq);
        end
        for (int i = 0; i < 16; i++) begin
            got = (ib + i < ia_q.size()) ? ia_q[ib + i] : -1;
            n_vec++;
            if (got !== exp_ia[i]) begin n_bad++; $display("FAIL base_imap_addr[%0d]: got %0d expected %0d", i, got, exp_ia[i]); end
            got = (ib + i < wa_q.size()) ? wa_q[ib + i] : -1;
            n_vec++;
            if (got !== i % 4) begin n_bad++; $display("FAIL base_w_addr[%0d]: got %0d expected %0d", i, got, i % 4); end
        end
        n_vec++;
        if (oa_q.size() - ob !== 4) begin n_bad++; $display("FAIL base_write_count: got %0d expected 4", oa_q.size() - ob); end
        for (int i = 0; i < 4; i++) begin
            got = (ob + i < oa_q.size()) ? oa_q[ob + i] : -1;
            n_vec++;
            if (got !== i) begin n_bad++; $display("FAIL base_obuf_addr[%0d]: got %0d expected %0d", i, got, i); end
            got = (ob + i < od_q.size()) ? od_q[ob + i] : -1;
            n_vec++;
            if (got !== 32) begin n_bad++; $display("FAIL base_obuf_data[%0d]: got %0d expected 32", i, got); end
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL base_back_idle: got busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_data_pattern();
        int ob, dc, gb, got;
        int exp_sum [4] = '{8, 12, 20, 24};
        for (int a = 0; a < 16; a++) imem[a] = 8'(a);
        ob = oa_q.size();
        run_map(0, 0, 0, dc, gb);
        for (int i = 0; i < 4; i++) begin
            got = (ob + i < od_q.size()) ? od_q[ob + i] : -1;
            n_vec++;
            if (got !== exp_sum[i]) begin n_bad++; $display("FAIL pattern_data[%0d]: got %0d expected %0d", i, got, exp_sum[i]); end
        end
        for (int a = 0; a < 16; a++) imem[a] = 8'h08;
    endtask

    task automatic test_hold();
        int ib, ob, dc, gb, vb, got;
        ib = ia_q.size(); ob = oa_q.size(); vb = vld_cnt;
        run_map(6, 3, 0, dc, gb);
        n_vec++;
        if (dc !== 21) begin n_bad++; $display("FAIL hold_done_cycle: got %0d expected 21", dc); end
        n_vec++;
        if (gb !== 0) begin n_bad++; $display("FAIL hold_gap: got %0d bad cycles expected 0", gb); end
        n_vec++;
        if (vld_cnt - vb !== 16) begin n_bad++; $display("FAIL hold_pe_vld_count: got %0d expected 16", vld_cnt - vb); end
        for (int i = 0; i < 16; i++) begin
            got = (ib + i < ia_q.size()) ? ia_q[ib + i] : -1;
            n_vec++;
            if (got !== exp_ia[i]) begin n_bad++; $display("FAIL hold_imap_addr[%0d]: got %0d expected %0d", i, got, exp_ia[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            got = (ob + i < od_q.size()) ? od_q[ob + i] * 4 + oa_q[ob + i] : -1;
            n_vec++;
            if (got !== 32 * 4 + i) begin n_bad++; $display("FAIL hold_write[%0d]: got data*4+addr %0d expected %0d", i, got, 128 + i); end
        end
    endtask

    task automatic test_start_in_run();
        int ib, ob, dc, gb, got;
        ib = ia_q.size(); ob = oa_q.size();
        run_map(0, 0, 7, dc, gb);
        n_vec++;
        if (dc !== 18) begin n_bad++; $display("FAIL restart_done_cycle: got %0d expected 18", dc); end
        for (int i = 0; i < 16; i++) begin
            got = (ib + i < ia_q.size()) ? ia_q[ib + i] : -1;
            n_vec++;
            if (got !== exp_ia[i]) begin n_bad++; $display("FAIL restart_imap_addr[%0d]: got %0d expected %0d", i, got, exp_ia[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            got = (ob + i < oa_q.size()) ? oa_q[ob + i] : -1;
            n_vec++;
            if (got !== i) begin n_bad++; $display("FAIL restart_obuf_addr[%0d]: got %0d expected %0d", i, got, i); end
        end
    endtask

    task automatic test_back_to_back();
        int ob, dc, gb, got;
        run_map(0, 0, 0, dc, gb);
        ob = oa_q.size();
        run_map(0, 0, 0, dc, gb);
        n_vec++;
        if (dc !== 18) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d expected 18", dc); end
        for (int i = 0; i < 4; i++) begin
            got = (ob + i < oa_q.size()) ? oa_q[ob + i] : -1;
            n_vec++;
            if (got !== i) begin n_bad++; $display("FAIL b2b_obuf_addr[%0d]: got %0d expected %0d", i, got, i); end
        end
    endtask

    task automatic test_reset_mid();
        int ib, ob, dc, gb, got;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (obuf_we !== 1'b1 || obuf_addr !== 2'd0 || obuf_data !== 8'h20) begin
            n_bad++;
            $display("FAIL first_write_latency: got we %b addr %0d data %0h expected 1 0 20", obuf_we, obuf_addr, obuf_data);
        end
        #1; rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, rd_en, pe_imap_vld, pe_weight_vld, obuf_we} !== 6'b0) begin
            n_bad++;
            $display("FAIL midrst_strobes: got %b expected 000000",
                     {busy, done, rd_en, pe_imap_vld, pe_weight_vld, obuf_we});
        end
        n_vec++;
        if (imap_addr !== 4'd0 || w_addr !== 2'd0 || obuf_addr !== 2'd0 || obuf_data !== 8'd0) begin
            n_bad++;
            $display("FAIL midrst_values: got imap %0d w %0d oaddr %0d odata %0h expected 0 0 0 0",
                     imap_addr, w_addr, obuf_addr, obuf_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        ib = ia_q.size(); ob = oa_q.size();
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (ia_q.size() - ib !== 0 || oa_q.size() - ob !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_quiet: got %0d issues %0d writes busy %b expected 0 0 0",
                     ia_q.size() - ib, oa_q.size() - ob, busy);
        end
        run_map(0, 0, 0, dc, gb);
        n_vec++;
        if (dc !== 18 || oa_q.size() - ob !== 4) begin
            n_bad++; $display("FAIL midrst_rerun: got done %0d writes %0d expected 18 4", dc, oa_q.size() - ob);
        end
        for (int i = 0; i < 4; i++) begin
            got = (ob + i < od_q.size()) ? od_q[ob + i] * 4 + oa_q[ob + i] : -1;
            n_vec++;
            if (got !== 128 + i) begin n_bad++; $display("FAIL midrst_write[%0d]: got data*4+addr %0d expected %0d", i, got, 128 + i); end
        end
    endtask

    task automatic test_default();
        int is0, wr0, cyc;
        is0 = d_issues; wr0 = d_writes;
        @(posedge clk); #1; d_start = 1'b1;
        @(posedge clk); #1; d_start = 1'b0; cyc = 1;
        while (!d_done && cyc < 25000) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (cyc !== 19602) begin n_bad++; $display("FAIL dflt_done_cycle: got %0d expected 19602", cyc); end
        @(posedge clk); #1;
        n_vec++;
        if (d_issues - is0 !== 19600) begin n_bad++; $display("FAIL dflt_issues: got %0d expected 19600", d_issues - is0); end
        n_vec++;
        if (d_writes - wr0 !== 784) begin n_bad++; $display("FAIL dflt_writes: got %0d expected 784", d_writes - wr0); end
        n_vec++;
        if (d_last_ia !== 1023 || d_last_wa !== 24) begin
            n_bad++; $display("FAIL dflt_last_addr: got imap %0d w %0d expected 1023 24", d_last_ia, d_last_wa);
        end
        n_vec++;
        if (d_last_oa !== 783 || d_last_od !== 90) begin
            n_bad++; $display("FAIL dflt_last_write: got addr %0d data %0d expected 783 90", d_last_oa, d_last_od);
        end
        n_vec++;
        if (d_busy !== 1'b0 || d_neq !== 0) begin
            n_bad++; $display("FAIL dflt_idle: got busy %b vld_unequal %0d expected 0 0", d_busy, d_neq);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        d_start = 1'b0; d_hold = 1'b0;
        for (int a = 0; a < 16; a++) imem[a] = 8'h08;
        for (int a = 0; a < 4; a++) wmem[a] = 8'h08;
        test_reset();
        test_base_map();
        test_data_pattern();
        test_hold();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid();
        test_default();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
